// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide physical-memory port between the
// instruction cache (read-only) and the data cache (read and write-back).
//
// One transaction runs at a time. In IDLE the arbiter picks a winner with
// round-robin priority, latches that side's command, and drives it to memory
// until pmem_resp. The response goes back to the granted cache only.
//
// Handshake: a cache raises its read/write strobe and holds it, along with its
// address and data, until its *_pmem_resp pulses for one cycle. Memory behaves
// the same way toward the arbiter: the arbiter holds pmem_read/pmem_write until
// pmem_resp pulses for one cycle. There is no separate ready signal. The resp
// pulse is both the acceptance and the completion of the transaction.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   icache_pmem_read/_address      I-cache line read request
//   icache_pmem_rdata/_resp        line data and done pulse to I-cache
//   dcache_pmem_read/_write        D-cache line read / write-back request
//   dcache_pmem_address/_wdata     D-cache line address and write-back data
//   dcache_pmem_rdata/_resp        line data and done pulse to D-cache
//   pmem_read/_write/_address      memory command (registered)
//   pmem_wdata                     memory write data (registered)
//   pmem_rdata/_resp               memory read data and done pulse
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // 1 means the D-cache won the most recent grant. It resets to 1 so the
  // I-cache wins the first tie.
  logic last_grant_d;

  logic                  cmd_read;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_WIDTH-1:0] cmd_wdata;

  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic i_done;
  logic d_done;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // Next-state and grant decision. Arbitration happens in IDLE only.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, the side that did not win last time gets the grant.
        if (i_req && (!d_req || last_grant_d)) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I: if (pmem_resp) state_next = IDLE;
      SERVE_D: if (pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      cmd_read     <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        last_grant_d <= 1'b0;
        cmd_read     <= 1'b1;
        cmd_write    <= 1'b0;
        cmd_addr     <= icache_pmem_address;
        cmd_wdata    <= '0;
      end else if (grant_d) begin
        // Read and write asserted together are treated as a write-back.
        last_grant_d <= 1'b1;
        cmd_read     <= dcache_pmem_read & ~dcache_pmem_write;
        cmd_write    <= dcache_pmem_write;
        cmd_addr     <= dcache_pmem_address;
        cmd_wdata    <= dcache_pmem_wdata;
      end
      if (i_done) i_rdata_q <= pmem_rdata;
      if (d_done) d_rdata_q <= pmem_rdata;
    end
  end

  // Completion is gated by rst so that an abandoned transaction never
  // reports a response, even if memory answers in the reset cycle.
  assign i_done = (state == SERVE_I) && pmem_resp && !rst;
  assign d_done = (state == SERVE_D) && pmem_resp && !rst;

  // The memory side depends only on registers, so the cache inputs have no
  // combinational path to memory.
  assign pmem_read    = (state != IDLE) && cmd_read;
  assign pmem_write   = (state != IDLE) && cmd_write;
  assign pmem_address = cmd_addr;
  assign pmem_wdata   = cmd_wdata;

  // Each rdata is passed through on its own resp cycle and then held.
  assign icache_pmem_resp  = i_done;
  assign dcache_pmem_resp  = d_done;
  assign icache_pmem_rdata = i_done ? pmem_rdata : i_rdata_q;
  assign dcache_pmem_rdata = d_done ? pmem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Directed scenario
// tasks are followed by a randomized run. The randomized run is checked
// against a transaction-level model of round-robin service.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int total = 0;
  int bad = 0;

  logic [AW-1:0] exp_q[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read(icache_pmem_read),
    .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata(icache_pmem_rdata),
    .icache_pmem_resp(icache_pmem_resp),
    .dcache_pmem_read(dcache_pmem_read),
    .dcache_pmem_write(dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address),
    .dcache_pmem_wdata(dcache_pmem_wdata),
    .dcache_pmem_rdata(dcache_pmem_rdata),
    .dcache_pmem_resp(dcache_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge. Inputs are driven there and
  // outputs are sampled #1 later, well away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
        bad++;
        $display("FAIL reset_strobes cyc=%0d got=%b exp=0000", i,
                 {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
      end
      total++;
      if (pmem_address !== '0 || pmem_wdata !== '0) begin
        bad++;
        $display("FAIL reset_cmd cyc=%0d addr=%h wdata=%h exp=0", i, pmem_address, pmem_wdata);
      end
      total++;
      if (icache_pmem_rdata !== '0 || dcache_pmem_rdata !== '0) begin
        bad++;
        $display("FAIL reset_rdata cyc=%0d i=%h d=%h exp=0", i, icache_pmem_rdata, dcache_pmem_rdata);
      end
    end
  endtask

  task automatic test_single_i();
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    #1;
    total++;
    if (pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL single_i_early got=%b exp=0", pmem_read);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
        bad++;
        $display("FAIL single_i_cmd cyc=%0d rd=%b wr=%b addr=%h exp=1/0/1230", i, pmem_read,
                 pmem_write, pmem_address);
      end
      total++;
      if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
        bad++;
        $display("FAIL single_i_noresp cyc=%0d i=%b d=%b exp=0", i, icache_pmem_resp, dcache_pmem_resp);
      end
    end
    pmem_rdata = a5;
    pmem_resp  = 1'b1;
    #1;
    total++;
    if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0 || icache_pmem_rdata !== a5) begin
      bad++;
      $display("FAIL single_i_resp iresp=%b dresp=%b rdata=%h exp=1/0/%h", icache_pmem_resp,
               dcache_pmem_resp, icache_pmem_rdata, a5);
    end
    cyc();
    pmem_resp        = 1'b0;
    pmem_rdata       = '1;
    icache_pmem_read = 1'b0;
    #1;
    total++;
    if (icache_pmem_resp !== 1'b0 || pmem_read !== 1'b0 || icache_pmem_rdata !== a5) begin
      bad++;
      $display("FAIL single_i_after iresp=%b rd=%b rdata=%h exp=0/0/%h", icache_pmem_resp, pmem_read,
               icache_pmem_rdata, a5);
    end
  endtask

  task automatic test_d_write();
    logic [LW-1:0] wd;
    logic [LW-1:0] rd;
    wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    rd = {$urandom, $urandom, $urandom, $urandom};
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h8000;
    dcache_pmem_wdata   = wd;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000 || pmem_wdata !== wd) begin
        bad++;
        $display("FAIL d_write_cmd cyc=%0d wr=%b rd=%b addr=%h wdata=%h", i, pmem_write, pmem_read,
                 pmem_address, pmem_wdata);
      end
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    total++;
    if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0 || dcache_pmem_rdata !== rd) begin
      bad++;
      $display("FAIL d_write_resp dresp=%b iresp=%b rdata=%h exp=1/0/%h", dcache_pmem_resp,
               icache_pmem_resp, dcache_pmem_rdata, rd);
    end
    total++;
    if (icache_pmem_rdata !== {16{8'hA5}}) begin
      bad++;
      $display("FAIL d_write_ihold got=%h exp=%h", icache_pmem_rdata, {16{8'hA5}});
    end
    cyc();
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    #1;
    total++;
    if (dcache_pmem_resp !== 1'b0 || pmem_write !== 1'b0) begin
      bad++;
      $display("FAIL d_write_after dresp=%b wr=%b exp=0/0", dcache_pmem_resp, pmem_write);
    end
  endtask

  // Both caches hold requests continuously; grants must alternate I,D,I,D
  // starting with I after reset, with a one-cycle dead gap between them.
  task automatic test_tie_alternation();
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [AW-1:0] exp_a;
    logic          exp_d;
    do_reset();
    ia = 16'h0010;
    da = 16'h4000;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = ia;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = da;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? 16'(ia + 16'(k * 16)) : 16'(da + 16'(k * 16)));
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 1);
      exp_a = exp_q.pop_front();
      #1;
      total++;
      if (pmem_read !== 1'b0) begin
        bad++;
        $display("FAIL tie_gap k=%0d got=%b exp=0", k, pmem_read);
      end
      cyc();
      total++;
      if (pmem_read !== 1'b1 || pmem_address !== exp_a) begin
        bad++;
        $display("FAIL tie_grant k=%0d rd=%b addr=%h exp=1/%h", k, pmem_read, pmem_address, exp_a);
      end
      cyc();
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp  = 1'b1;
      #1;
      total++;
      if (icache_pmem_resp !== !exp_d || dcache_pmem_resp !== exp_d) begin
        bad++;
        $display("FAIL tie_resp k=%0d i=%b d=%b exp=%b/%b", k, icache_pmem_resp, dcache_pmem_resp,
                 !exp_d, exp_d);
      end
      cyc();
      pmem_resp = 1'b0;
      // Both sides advance their address on every round so each grant is
      // identifiable; the served side starts a fresh request.
      icache_pmem_address = icache_pmem_address + 16'h0010;
      dcache_pmem_address = dcache_pmem_address + 16'h0010;
    end
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] rd;
    rd = {$urandom, $urandom, $urandom, $urandom};
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h2220;
    dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    total++;
    if (pmem_write !== 1'b1) begin
      bad++;
      $display("FAIL rmid_start got=%b exp=1", pmem_write);
    end
    cyc();
    rst               = 1'b1;
    dcache_pmem_write = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== '0 || dcache_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after wr=%b rd=%b addr=%h dresp=%b exp=0", pmem_write, pmem_read,
               pmem_address, dcache_pmem_resp);
    end
    pmem_resp = 1'b1;
    #1;
    total++;
    if (dcache_pmem_resp !== 1'b0 || icache_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL rmid_stray d=%b i=%b exp=0", dcache_pmem_resp, icache_pmem_resp);
    end
    cyc();
    pmem_resp = 1'b0;
    // last_grant returns to D on reset, so I must win this tie.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h0ABC;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h0DEF;
    cyc();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h0ABC) begin
      bad++;
      $display("FAIL rmid_i_grant rd=%b addr=%h exp=1/0abc", pmem_read, pmem_address);
    end
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    total++;
    if (icache_pmem_resp !== 1'b1 || icache_pmem_rdata !== rd) begin
      bad++;
      $display("FAIL rmid_i_resp resp=%b rdata=%h exp=1/%h", icache_pmem_resp, icache_pmem_rdata, rd);
    end
    cyc();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;
    cyc();
  endtask

  task automatic test_protocol_edges();
    dcache_pmem_read    = 1'b1;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h3000;
    cyc();
    total++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h3000) begin
      bad++;
      $display("FAIL edge_rw wr=%b rd=%b addr=%h exp=1/0/3000", pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    total++;
    if (dcache_pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL edge_rw_resp got=%b exp=1", dcache_pmem_resp);
    end
    cyc();
    pmem_resp         = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    // I request dropped and address changed mid-transaction.
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h5550;
    cyc();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = 16'hFFFF;
    cyc();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 16'h5550) begin
      bad++;
      $display("FAIL edge_drop_hold rd=%b addr=%h exp=1/5550", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    #1;
    total++;
    if (icache_pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL edge_drop_resp got=%b exp=1", icache_pmem_resp);
    end
    cyc();
    pmem_resp = 1'b0;
    cyc();
    // Stray memory response while idle.
    pmem_resp = 1'b1;
    #1;
    total++;
    if (icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL edge_stray i=%b d=%b exp=0", icache_pmem_resp, dcache_pmem_resp);
    end
    cyc();
    pmem_resp = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      bad++;
      $display("FAIL edge_stray_idle rd=%b wr=%b exp=0", pmem_read, pmem_write);
    end
  endtask

  // Randomized traffic. The model tracks which caches have a pending request,
  // who was served last, and the line data each cache last received.
  task automatic test_random();
    logic          i_pend;
    logic          d_pend;
    logic          ref_last_d;
    logic          win_d;
    logic [LW-1:0] exp_i_rdata;
    logic [LW-1:0] exp_d_rdata;
    logic [LW-1:0] rd_val;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wd;
    logic          exp_rd;
    logic          exp_wr;
    int            sel;
    int            lat;
    clear_inputs();
    do_reset();
    i_pend      = 1'b0;
    d_pend      = 1'b0;
    ref_last_d  = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    for (int it = 0; it < 80; it++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) begin
        i_pend              = 1'b1;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'($urandom);
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend              = 1'b1;
        sel                 = $urandom_range(0, 2);
        dcache_pmem_read    = (sel != 1);
        dcache_pmem_write   = (sel != 0);
        dcache_pmem_address = 16'($urandom);
        dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!i_pend && !d_pend) begin
        pmem_resp = 1'($urandom_range(0, 1));
        #1;
        total++;
        if ({icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write} !== 4'b0) begin
          bad++;
          $display("FAIL rnd_idle it=%0d got=%b exp=0000", it,
                   {icache_pmem_resp, dcache_pmem_resp, pmem_read, pmem_write});
        end
        cyc();
        pmem_resp = 1'b0;
        continue;
      end
      win_d    = d_pend && (!i_pend || !ref_last_d);
      exp_addr = win_d ? dcache_pmem_address : icache_pmem_address;
      exp_wr   = win_d && dcache_pmem_write;
      exp_rd   = !exp_wr;
      exp_wd   = dcache_pmem_wdata;
      #1;
      total++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        bad++;
        $display("FAIL rnd_gap it=%0d rd=%b wr=%b exp=0/0", it, pmem_read, pmem_write);
      end
      lat = $urandom_range(1, 5);
      for (int c = 0; c < lat; c++) begin
        cyc();
        total++;
        if (pmem_read !== exp_rd || pmem_write !== exp_wr || pmem_address !== exp_addr ||
            (win_d && pmem_wdata !== exp_wd) || icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
          bad++;
          $display("FAIL rnd_cmd it=%0d c=%0d rd=%b wr=%b addr=%h exp=%b/%b/%h", it, c, pmem_read,
                   pmem_write, pmem_address, exp_rd, exp_wr, exp_addr);
        end
        // The winner scribbling on its inputs mid-transaction has no effect.
        if (win_d) begin
          dcache_pmem_address = 16'($urandom);
          dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          icache_pmem_address = 16'($urandom);
        end
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      rd_val     = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = rd_val;
      pmem_resp  = 1'b1;
      #1;
      total++;
      if (win_d ? (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0 || dcache_pmem_rdata !== rd_val ||
                   icache_pmem_rdata !== exp_i_rdata)
                : (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0 || icache_pmem_rdata !== rd_val ||
                   dcache_pmem_rdata !== exp_d_rdata)) begin
        bad++;
        $display("FAIL rnd_resp it=%0d win_d=%b iresp=%b dresp=%b irdata=%h drdata=%h data=%h", it, win_d,
                 icache_pmem_resp, dcache_pmem_resp, icache_pmem_rdata, dcache_pmem_rdata, rd_val);
      end
      cyc();
      pmem_resp  = 1'b0;
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      ref_last_d = win_d;
      if (win_d) begin
        exp_d_rdata       = rd_val;
        d_pend            = 1'b0;
        dcache_pmem_read  = 1'b0;
        dcache_pmem_write = 1'b0;
      end else begin
        exp_i_rdata      = rd_val;
        i_pend           = 1'b0;
        icache_pmem_read = 1'b0;
      end
      #1;
      total++;
      if (icache_pmem_rdata !== exp_i_rdata || dcache_pmem_rdata !== exp_d_rdata ||
          icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
        bad++;
        $display("FAIL rnd_hold it=%0d i=%h d=%h exp=%h/%h", it, icache_pmem_rdata, dcache_pmem_rdata,
                 exp_i_rdata, exp_d_rdata);
      end
    end
    icache_pmem_read  = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_i();
    test_d_write();
    test_tie_alternation();
    test_reset_mid();
    test_protocol_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
